pico9_uart: RTL and testbench
=============================

// Module: pico9_uart
// PURPOSE
//  Responder on the Pico9 CPU I/O port bus: 8N1 UART with TX and RX FIFOs.
//  Decodes the CPU's port/iord/iowr strobes, supplies read data on the CPU's data_in and takes
//  write data from the CPU's data_out. Sits beside the CPU at top level; txd/rxd go to pins.
// PARAMETERS
//  IOMSB        3    port bus width; matches the CPU's I/O port width
//  FIFO_LOG2    3    log2 of depth of each FIFO (8 entries)
//  DIV_W        16   baud divisor width
//  DEFAULT_DIV  433  divisor loaded at reset; bit period = DIV+1 clocks
// PORTS
//  clk     in   1          sole clock, rising edge
//  reset   in   1          synchronous, active-high
//  port    in   IOMSB      register index (CPU port)
//  iord    in   1          read strobe, one cycle per CPU read
//  iowr    in   1          write strobe, one cycle per CPU write
//  wdata   in   9          write data (CPU data_out), valid when iowr=1
//  rdata   out  9          read data (CPU data_in), combinational from port and state
//  rxd     in   1          serial in, asynchronous
//  txd     out  1          serial out, idle high
//  irq     out  1          level interrupt request
// BEHAVIOUR
//  Bus: rdata valid in the same cycle as port; CPU samples it at the edge ending the iord cycle.
//   Side effects (pop, push, register update) take effect at that edge. iord/iowr never both high.
//  Read map: 0 RXDATA {1'b0,byte}; pops if RX non-empty, returns 0 and no pop if empty.
//   1 STATUS {3'b0,tx_ie,rx_ie,ferr,ovr,tx_idle,rx_ne}; wait: bit0 rx_ne, bit1 tx_full, bit2 tx_idle,
//   bit3 ovr (sticky), bit4 ferr (sticky), bits8:5 = 0. 2 RX count, 3 TX count (0..2^FIFO_LOG2).
//   4..7 read 0.
//  Write map: 0 TXDATA push wdata[7:0]; dropped silently when TX full.
//   1 CTRL: b0=1 clear ovr+ferr, b1=1 flush RX, b2=1 flush TX, b3 rx_ie, b4 tx_ie (b3/b4 stored).
//   2 DIV[8:0] <= wdata; 3 DIV[DIV_W-1:9] <= wdata. Written value <3 is stored as 3.
//   4..7 ignored.
//  FIFOs: circular, wrap on pointer overflow; simultaneous push+pop keeps count; full+pop+push legal.
//  Baud: per-engine counter 0..DIV; bit boundary when counter==DIV. DIV change applies at next
//   boundary; software changes it only when idle.
//  TX FSM IDLE->START->DATA(8, LSB first)->STOP->IDLE. IDLE with TX non-empty: pop, txd=0 next cycle.
//   Each state holds DIV+1 clocks. End of STOP with FIFO non-empty loads next byte directly into
//   START (no idle gap). tx_idle = IDLE & TX FIFO empty. TX flush empties FIFO; shifter finishes frame.
//  RX: rxd via 2-flop synchroniser (2-cycle latency). IDLE: 1->0 edge -> START, wait (DIV+1)>>1 clocks,
//   sample; high = false start -> IDLE. Then 8 data samples every DIV+1 clocks, LSB first, then stop
//   sample. Stop=1: push byte; if full, drop and set ovr unless a pop occurs same cycle (then push ok).
//   Stop=0: discard byte, set ferr. Return to IDLE after stop sample (new start accepted at once).
//   RX flush in same cycle as receiver push: flush wins, byte lost, ovr unchanged.
//  Sticky clear and new error same cycle: error wins (bit stays set).
//  irq = rx_ie & rx_ne | tx_ie & TX FIFO empty; registered-state only, no latency beyond state.
//  Reset (any time, incl. mid-frame): FIFOs empty, both FSMs IDLE, txd=1, irq=0, ovr=ferr=0,
//   rx_ie=tx_ie=0, DIV=DEFAULT_DIV; rdata then reflects reset state (STATUS=0x004).
// TESTING
//  DIV=3; write port0 0x0A5 -> txd low 4 clk, then 1,0,1,0,0,1,0,1 x4 clk, high 4; STATUS=0x004 after.
//  Write 9 bytes 0x01..0x09 while DIV=3 -> 0x01 enters shifter, 8 queue, 9th... TX count peaks at 8,
//   back-to-back frames with no idle gap, all 9 bytes transmitted (first popped before 9th push).
//  Drive rxd 8N1 0x3C at DIV=3 -> STATUS bit0=1, RX count=1; read port0 -> 0x03C, then STATUS bit0=0.
//  Send 9 frames with no reads -> RX count=8, STATUS bit3=1; write CTRL 0x001 -> bit3=0, data intact.
//  rxd frame with stop=0 -> no push, STATUS bit4=1; 2-clk rxd glitch low -> no frame, no flag.
//  Assert reset mid TX frame -> next cycle txd=1, STATUS=0x004, DIV reads back as transmit 434-clk bits.

Source files
------------

// File: rtl/pico9_uart.sv
// pico9_uart: 8N1 UART responder on the Pico9 CPU I/O port bus.
// TX and RX FIFOs, programmable baud divisor, sticky error flags and a level interrupt.
module pico9_uart #(
  parameter int IOMSB       = 3,
  parameter int FIFO_LOG2   = 3,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 433
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IOMSB-1:0] port,
  input  logic             iord,
  input  logic             iowr,
  input  logic [8:0]       wdata,
  output logic [8:0]       rdata,
  input  logic             rxd,
  output logic             txd,
  output logic             irq
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int PW    = FIFO_LOG2 + 1;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic [DIV_W-1:0] div_q, div_wr;
  logic             rx_ie, tx_ie, ovr, ferr;
  logic             wr_tx, wr_ctrl, wr_divl, wr_divh;

  logic [7:0]    tx_mem [DEPTH];
  logic [PW-1:0] tx_wp, tx_rp, tx_count;
  logic [7:0]    tx_head;
  logic          tx_empty, tx_full, tx_push, tx_pop, tx_flush, tx_avail, tx_idle;

  logic [7:0]    rx_mem [DEPTH];
  logic [PW-1:0] rx_wp, rx_rp, rx_count;
  logic [7:0]    rx_head;
  logic          rx_empty, rx_full, rx_push, rx_pop, rx_flush;
  logic          rx_push_req, rx_ferr_evt, ovr_evt;

  tx_state_t        tx_state, tx_state_nx;
  logic [DIV_W-1:0] tx_cnt, tx_cnt_nx, tx_div, tx_div_nx;
  logic [7:0]       tx_sh, tx_sh_nx;
  logic [2:0]       tx_bit, tx_bit_nx;

  rx_state_t        rx_state, rx_state_nx;
  logic [DIV_W-1:0] rx_cnt, rx_cnt_nx, rx_div, rx_div_nx, rx_mid;
  logic [7:0]       rx_sh, rx_sh_nx;
  logic [2:0]       rx_bit, rx_bit_nx;
  logic             rx_meta, rx_s, rx_prev;

  assign wr_tx   = iowr && (port == IOMSB'(0));
  assign wr_ctrl = iowr && (port == IOMSB'(1));
  assign wr_divl = iowr && (port == IOMSB'(2));
  assign wr_divh = iowr && (port == IOMSB'(3));

  assign tx_flush = wr_ctrl && wdata[2];
  assign rx_flush = wr_ctrl && wdata[1];

  assign tx_count = tx_wp - tx_rp;
  assign tx_empty = (tx_count == '0);
  assign tx_full  = (tx_count == PW'(DEPTH));
  assign tx_head  = tx_mem[tx_rp[FIFO_LOG2-1:0]];
  assign tx_avail = !tx_empty && !tx_flush;
  assign tx_push  = wr_tx && !tx_flush && (!tx_full || tx_pop);
  assign tx_idle  = (tx_state == TX_IDLE) && tx_empty;

  assign rx_count = rx_wp - rx_rp;
  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == PW'(DEPTH));
  assign rx_head  = rx_mem[rx_rp[FIFO_LOG2-1:0]];
  assign rx_pop   = iord && (port == IOMSB'(0)) && !rx_empty;
  // A pop in the same cycle frees the slot the receiver needs
  assign rx_push  = rx_push_req && !rx_flush && (!rx_full || rx_pop);
  assign ovr_evt  = rx_push_req && !rx_flush && rx_full && !rx_pop;

  assign irq = (rx_ie && !rx_empty) || (tx_ie && tx_empty);

  always_comb begin
    div_wr = div_q;
    if (wr_divl) div_wr[8:0] = wdata;
    if (wr_divh) div_wr[DIV_W-1:9] = wdata[DIV_W-10:0];
    if (div_wr < DIV_W'(3)) div_wr = DIV_W'(3);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= DIV_W'(DEFAULT_DIV);
      rx_ie <= 1'b0;
      tx_ie <= 1'b0;
      ovr   <= 1'b0;
      ferr  <= 1'b0;
    end else begin
      if (wr_divl || wr_divh) div_q <= div_wr;
      if (wr_ctrl) begin
        rx_ie <= wdata[3];
        tx_ie <= wdata[4];
      end
      // A new error outranks a clear issued in the same cycle
      if (ovr_evt) ovr <= 1'b1;
      else if (wr_ctrl && wdata[0]) ovr <= 1'b0;
      if (rx_ferr_evt) ferr <= 1'b1;
      else if (wr_ctrl && wdata[0]) ferr <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || tx_flush) begin
      tx_wp <= '0;
      tx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + PW'(1);
      if (tx_pop)  tx_rp <= tx_rp + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[FIFO_LOG2-1:0]] <= wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset || rx_flush) begin
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + PW'(1);
      if (rx_pop)  rx_rp <= rx_rp + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp[FIFO_LOG2-1:0]] <= rx_sh;
  end

  always_comb begin
    rdata = '0;
    case (port)
      IOMSB'(0): rdata = rx_empty ? 9'h000 : {1'b0, rx_head};
      IOMSB'(1): rdata = {4'b0000, ferr, ovr, tx_idle, tx_full, !rx_empty};
      IOMSB'(2): rdata = 9'(rx_count);
      IOMSB'(3): rdata = 9'(tx_count);
      default:   rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_div   <= DIV_W'(DEFAULT_DIV);
      tx_sh    <= '0;
      tx_bit   <= '0;
      txd      <= 1'b1;
    end else begin
      tx_state <= tx_state_nx;
      tx_cnt   <= tx_cnt_nx;
      tx_div   <= tx_div_nx;
      tx_sh    <= tx_sh_nx;
      tx_bit   <= tx_bit_nx;
      case (tx_state_nx)
        TX_START: txd <= 1'b0;
        TX_DATA:  txd <= tx_sh_nx[0];
        default:  txd <= 1'b1;
      endcase
    end
  end

  // The divisor is re-latched only at bit boundaries so a frame never stretches mid-bit
  always_comb begin
    tx_state_nx = tx_state;
    tx_cnt_nx   = tx_cnt + DIV_W'(1);
    tx_div_nx   = tx_div;
    tx_sh_nx    = tx_sh;
    tx_bit_nx   = tx_bit;
    tx_pop      = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_nx = '0;
        tx_div_nx = div_q;
        if (tx_avail) begin
          tx_pop      = 1'b1;
          tx_sh_nx    = tx_head;
          tx_state_nx = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt == tx_div) begin
          tx_cnt_nx   = '0;
          tx_div_nx   = div_q;
          tx_bit_nx   = '0;
          tx_state_nx = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_cnt == tx_div) begin
          tx_cnt_nx = '0;
          tx_div_nx = div_q;
          tx_sh_nx  = {1'b0, tx_sh[7:1]};
          tx_bit_nx = tx_bit + 3'd1;
          if (tx_bit == 3'd7) tx_state_nx = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_cnt == tx_div) begin
          tx_cnt_nx = '0;
          tx_div_nx = div_q;
          if (tx_avail) begin
            tx_pop      = 1'b1;
            tx_sh_nx    = tx_head;
            tx_state_nx = TX_START;
          end else begin
            tx_state_nx = TX_IDLE;
          end
        end
      end
      default: tx_state_nx = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_div   <= DIV_W'(DEFAULT_DIV);
      rx_sh    <= '0;
      rx_bit   <= '0;
    end else begin
      rx_meta  <= rxd;
      rx_s     <= rx_meta;
      rx_prev  <= rx_s;
      rx_state <= rx_state_nx;
      rx_cnt   <= rx_cnt_nx;
      rx_div   <= rx_div_nx;
      rx_sh    <= rx_sh_nx;
      rx_bit   <= rx_bit_nx;
    end
  end

  // (DIV+1)>>1 clocks after the falling edge, expressed as a terminal count
  assign rx_mid = (rx_div - DIV_W'(1)) >> 1;

  always_comb begin
    rx_state_nx = rx_state;
    rx_cnt_nx   = rx_cnt + DIV_W'(1);
    rx_div_nx   = rx_div;
    rx_sh_nx    = rx_sh;
    rx_bit_nx   = rx_bit;
    rx_push_req = 1'b0;
    rx_ferr_evt = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_nx = '0;
        rx_div_nx = div_q;
        if (rx_prev && !rx_s) rx_state_nx = RX_START;
      end
      RX_START: begin
        if (rx_cnt == rx_mid) begin
          rx_cnt_nx   = '0;
          rx_div_nx   = div_q;
          rx_bit_nx   = '0;
          rx_state_nx = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == rx_div) begin
          rx_cnt_nx = '0;
          rx_div_nx = div_q;
          rx_sh_nx  = {rx_s, rx_sh[7:1]};
          rx_bit_nx = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state_nx = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt == rx_div) begin
          rx_state_nx = RX_IDLE;
          if (rx_s) rx_push_req = 1'b1;
          else rx_ferr_evt = 1'b1;
        end
      end
      default: rx_state_nx = RX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pico9_uart.sv
// tb_pico9_uart: self-checking bench for pico9_uart.
// Register table, serial frame models built from byte values, and randomized TX/RX traffic.
module tb_pico9_uart;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] port = '0;
  logic       iord = 1'b0;
  logic       iowr = 1'b0;
  logic [8:0] wdata = '0;
  logic [8:0] rdata;
  logic       rxd = 1'b1;
  logic       txd;
  logic       irq;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    bit         wr;
    logic [2:0] port;
    logic [8:0] data;
    logic [8:0] expRd;
    bit         expIrq;
  } vec_t;

  vec_t       vecs[13];
  logic [7:0] rxq[$];
  int         startCyc[9];

  pico9_uart dut (
    .clk(clk), .reset(reset), .port(port), .iord(iord), .iowr(iowr),
    .wdata(wdata), .rdata(rdata), .rxd(rxd), .txd(txd), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // All bus tasks start and end on a falling edge
  task automatic busWrite(input logic [2:0] p, input logic [8:0] d);
    port = p; wdata = d; iowr = 1'b1;
    @(negedge clk);
    iowr = 1'b0;
  endtask

  task automatic busRead(input logic [2:0] p, output logic [8:0] d);
    port = p; iord = 1'b1;
    #1 d = rdata;
    @(negedge clk);
    iord = 1'b0;
  endtask

  task automatic readCheck(input logic [2:0] p, input int expected, input string name);
    logic [8:0] d;
    busRead(p, d);
    checkOutput(name, int'(d), expected);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    logic [8:0] d;
    if (v.wr) begin
      busWrite(v.port, v.data);
    end else begin
      busRead(v.port, d);
      checkOutput($sformatf("vec%0d_rd", idx), int'(d), int'(v.expRd));
    end
    checkOutput($sformatf("vec%0d_irq", idx), int'(irq), int'(v.expIrq));
  endtask

  function automatic logic frameLevel(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    else if (idx <= 8) return b[idx-1];
    else return 1'b1;
  endfunction

  // Waits for a start bit, then compares every clock of the frame against the 8N1 shape
  task automatic captureWave(input logic [7:0] b, input int bitclk, input int limit,
                             input string name, output int sc);
    bit found = 1'b0;
    int bad = 0;
    sc = 0;
    for (int i = 0; i < limit; i++) begin
      if (txd == 1'b0) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput({name, "_start"}, int'(found), 1);
    if (found) begin
      sc = cyc;
      for (int k = 0; k < 10 * bitclk; k++) begin
        if (k > 0) @(negedge clk);
        if (txd !== frameLevel(b, k / bitclk)) bad++;
      end
      checkOutput({name, "_wave"}, bad, 0);
    end
  endtask

  task automatic sendRx(input logic [7:0] b, input logic stopBit, input int bitclk);
    rxd = 1'b0;
    repeat (bitclk) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (bitclk) @(negedge clk);
    end
    rxd = stopBit;
    repeat (bitclk) @(negedge clk);
    rxd = 1'b1;
  endtask

  function automatic int expStatus(input bit txIdle, input bit txFull, input bit ovrM, input bit ferrM);
    return (ferrM ? 16 : 0) | (ovrM ? 8 : 0) | (txIdle ? 4 : 0) | (txFull ? 2 : 0)
           | ((rxq.size() > 0) ? 1 : 0);
  endfunction

  task automatic setDiv(input int div);
    busWrite(3'd3, 9'(div >> 9));
    busWrite(3'd2, 9'(div & 511));
  endtask

  initial begin
    logic [8:0] d;
    logic [7:0] b;
    bit         ovrM;
    int         div, n, lowRun, sc;
    bit         found;

    vecs[0]  = '{1'b0, 3'd1, 9'h000, 9'h004, 1'b0};
    vecs[1]  = '{1'b0, 3'd2, 9'h000, 9'h000, 1'b0};
    vecs[2]  = '{1'b0, 3'd3, 9'h000, 9'h000, 1'b0};
    vecs[3]  = '{1'b0, 3'd0, 9'h000, 9'h000, 1'b0};
    vecs[4]  = '{1'b0, 3'd5, 9'h000, 9'h000, 1'b0};
    vecs[5]  = '{1'b0, 3'd7, 9'h000, 9'h000, 1'b0};
    vecs[6]  = '{1'b1, 3'd1, 9'h010, 9'h000, 1'b1};
    vecs[7]  = '{1'b1, 3'd1, 9'h008, 9'h000, 1'b0};
    vecs[8]  = '{1'b1, 3'd5, 9'h1FF, 9'h000, 1'b0};
    vecs[9]  = '{1'b0, 3'd1, 9'h000, 9'h004, 1'b0};
    vecs[10] = '{1'b1, 3'd3, 9'h000, 9'h000, 1'b0};
    vecs[11] = '{1'b1, 3'd2, 9'h001, 9'h000, 1'b0};
    vecs[12] = '{1'b0, 3'd1, 9'h000, 9'h004, 1'b0};

    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkOutput("txd_reset", int'(txd), 1);
    checkOutput("irq_reset", int'(irq), 0);

    // Register map; the last two writes request DIV=1, which must clamp to 3
    for (int i = 0; i < 13; i++) applyStimulus(vecs[i], i);

    $display("[TB] single frame 0x0A5 at clamped divisor");
    busWrite(3'd0, 9'h0A5);
    captureWave(8'hA5, 4, 20, "tx_a5", sc);
    repeat (2) @(negedge clk);
    readCheck(3'd1, 'h004, "status_after_a5");

    $display("[TB] nine back-to-back bytes");
    fork
      begin
        for (int i = 1; i <= 9; i++) busWrite(3'd0, 9'(i));
        readCheck(3'd3, 8, "txcount_peak");
        readCheck(3'd1, 'h002, "status_tx_full");
      end
      begin
        for (int f = 0; f < 9; f++)
          captureWave(8'(f + 1), 4, 50, $sformatf("tx_burst%0d", f), startCyc[f]);
      end
    join
    for (int f = 1; f < 9; f++)
      checkOutput($sformatf("tx_gap%0d", f), startCyc[f] - startCyc[f-1], 40);
    repeat (2) @(negedge clk);
    readCheck(3'd1, 'h004, "status_after_burst");

    $display("[TB] receive 0x3C");
    sendRx(8'h3C, 1'b1, 4);
    rxq.push_back(8'h3C);
    repeat (8) @(negedge clk);
    readCheck(3'd1, expStatus(1, 0, 0, 0), "status_rx_ne");
    readCheck(3'd2, 1, "rxcount_one");
    checkOutput("irq_rx", int'(irq), 1);
    readCheck(3'd0, int'(rxq.pop_front()), "rxdata_3c");
    readCheck(3'd1, expStatus(1, 0, 0, 0), "status_rx_empty");
    checkOutput("irq_rx_drained", int'(irq), 0);

    $display("[TB] RX overflow");
    ovrM = 1'b0;
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      sendRx(b, 1'b1, 4);
      if (rxq.size() < 8) rxq.push_back(b);
      else ovrM = 1'b1;
    end
    repeat (8) @(negedge clk);
    readCheck(3'd2, rxq.size(), "rxcount_full");
    readCheck(3'd1, expStatus(1, 0, ovrM, 0), "status_ovr");
    busWrite(3'd1, 9'h009);
    readCheck(3'd1, expStatus(1, 0, 0, 0), "status_ovr_cleared");
    n = rxq.size();
    for (int i = 0; i < n; i++) readCheck(3'd0, int'(rxq.pop_front()), $sformatf("ovr_data%0d", i));
    readCheck(3'd0, 0, "rxdata_empty_again");

    $display("[TB] framing error and glitch");
    sendRx(8'h55, 1'b0, 4);
    repeat (8) @(negedge clk);
    readCheck(3'd2, 0, "rxcount_ferr");
    readCheck(3'd1, expStatus(1, 0, 0, 1), "status_ferr");
    busWrite(3'd1, 9'h009);
    readCheck(3'd1, expStatus(1, 0, 0, 0), "status_ferr_cleared");
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    repeat (60) @(negedge clk);
    readCheck(3'd2, 0, "rxcount_glitch");
    readCheck(3'd1, expStatus(1, 0, 0, 0), "status_glitch");

    $display("[TB] RX flush");
    sendRx(8'h81, 1'b1, 4);
    sendRx(8'h7E, 1'b1, 4);
    repeat (8) @(negedge clk);
    readCheck(3'd2, 2, "rxcount_before_flush");
    busWrite(3'd1, 9'h00A);
    readCheck(3'd2, 0, "rxcount_flushed");
    readCheck(3'd1, expStatus(1, 0, 0, 0), "status_flushed");

    $display("[TB] randomized divisor traffic");
    for (int it = 0; it < 4; it++) begin
      div = $urandom_range(9, 3);
      setDiv(div);
      b = 8'($urandom);
      busWrite(3'd0, {1'b0, b});
      captureWave(b, div + 1, 20, $sformatf("rnd_tx%0d", it), sc);
      repeat (2) @(negedge clk);
      n = $urandom_range(8, 1);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        sendRx(b, 1'b1, div + 1);
        rxq.push_back(b);
      end
      repeat (3 * (div + 1)) @(negedge clk);
      readCheck(3'd2, rxq.size(), $sformatf("rnd_rxcount%0d", it));
      checkOutput($sformatf("rnd_irq%0d", it), int'(irq), 1);
      for (int i = 0; i < n; i++)
        readCheck(3'd0, int'(rxq.pop_front()), $sformatf("rnd_rx%0d_%0d", it, i));
      checkOutput($sformatf("rnd_irq_clear%0d", it), int'(irq), 0);
    end

    $display("[TB] reset during a frame");
    busWrite(3'd0, 9'h05A);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("txd_after_reset", int'(txd), 1);
    checkOutput("irq_after_reset", int'(irq), 0);
    readCheck(3'd1, 'h004, "status_after_reset");
    readCheck(3'd3, 0, "txcount_after_reset");
    busWrite(3'd0, 9'h001);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (txd == 1'b0) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("default_div_start", int'(found), 1);
    lowRun = 0;
    while (found && txd == 1'b0 && lowRun < 1000) begin
      lowRun++;
      @(negedge clk);
    end
    checkOutput("default_div_bit", lowRun, 434);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
